// File: rtl/stopwatch_bcd.sv
// BCD mm:ss stopwatch advanced by the one-second tick, with IDLE/RUN/PAUSE control.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int MAX_MIN_TENS = 5,
  parameter int MAX_MIN_ONES = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       wrap,
  output logic       lap_active
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [2:0] MaxMinTens = 3'(MAX_MIN_TENS);
  localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN_ONES);

  state_t     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic       running_q;
  logic       wrap_q, wrap_d;
  logic       full_scale;

  assign full_scale = (min_tens_q == MaxMinTens) && (min_ones_q == MaxMinOnes) &&
                      (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);

  // A tick is counted only from the registered RUN state, so a same-cycle stop still counts it.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        PAUSE:   if (start) state_d = RUN;
        RUN: begin
          if (tick) begin
            if (full_scale) begin
              sec_ones_d = '0;
              sec_tens_d = '0;
              min_ones_d = '0;
              min_tens_d = '0;
              wrap_d     = 1'b1;
            end else if (sec_ones_q != 4'd9) begin
              sec_ones_d = sec_ones_q + 4'd1;
            end else begin
              sec_ones_d = '0;
              if (sec_tens_q != 3'd5) begin
                sec_tens_d = sec_tens_q + 3'd1;
              end else begin
                sec_tens_d = '0;
                if (min_ones_q != 4'd9) begin
                  min_ones_d = min_ones_q + 4'd1;
                end else begin
                  min_ones_d = '0;
                  min_tens_d = min_tens_q + 3'd1;
                end
              end
            end
          end
          if (stop) state_d = PAUSE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= (state_d == RUN);
      wrap_q     <= wrap_d;
    end
  end

  assign running = running_q;
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_d;
  logic [3:0] disp_sec_ones_q, disp_sec_ones_d;
  logic [2:0] disp_sec_tens_q, disp_sec_tens_d;
  logic [3:0] disp_min_ones_q, disp_min_ones_d;
  logic [2:0] disp_min_tens_q, disp_min_tens_d;

  // Freezing captures the count as it stood at the lap edge; unfreezing shows the live next count.
  always_comb begin
    lap_d = lap_q;
    if (clear) lap_d = 1'b0;
    else if (state_q == RUN && lap) lap_d = !lap_q;
    disp_sec_ones_d = sec_ones_d;
    disp_sec_tens_d = sec_tens_d;
    disp_min_ones_d = min_ones_d;
    disp_min_tens_d = min_tens_d;
    if (lap_d && lap_q) begin
      disp_sec_ones_d = disp_sec_ones_q;
      disp_sec_tens_d = disp_sec_tens_q;
      disp_min_ones_d = disp_min_ones_q;
      disp_min_tens_d = disp_min_tens_q;
    end else if (lap_d) begin
      disp_sec_ones_d = sec_ones_q;
      disp_sec_tens_d = sec_tens_q;
      disp_min_ones_d = min_ones_q;
      disp_min_tens_d = min_tens_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lap_q           <= 1'b0;
      disp_sec_ones_q <= '0;
      disp_sec_tens_q <= '0;
      disp_min_ones_q <= '0;
      disp_min_tens_q <= '0;
    end else begin
      lap_q           <= lap_d;
      disp_sec_ones_q <= disp_sec_ones_d;
      disp_sec_tens_q <= disp_sec_tens_d;
      disp_min_ones_q <= disp_min_ones_d;
      disp_min_tens_q <= disp_min_tens_d;
    end
  end

  assign sec_ones   = disp_sec_ones_q;
  assign sec_tens   = disp_sec_tens_q;
  assign min_ones   = disp_min_ones_q;
  assign min_tens   = disp_min_tens_q;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign sec_ones   = sec_ones_q;
  assign sec_tens   = sec_tens_q;
  assign min_ones   = min_ones_q;
  assign min_tens   = min_tens_q;
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: the count is modelled as plain elapsed seconds, digits derived arithmetically.
// Directed scenarios pin the model with literal displays, then random control traffic runs against it.
module tb_stopwatch_bcd;

  localparam int MaxMinTens = 5;
  localparam int MaxMinOnes = 9;
  localparam int FullScale  = (MaxMinTens * 10 + MaxMinOnes) * 60 + 59;
  localparam int MIdle = 0, MRun = 1, MPause = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic       running, wrap, lap_active;

  int total = 0;
  int bad = 0;
  int mTotal = 0;
  int mState = MIdle;
  int mSnap = 0;
  bit mWrap = 1'b0;
  bit mLap = 1'b0;
  bit checkEn = 1'b0;

  stopwatch_bcd #(.MAX_MIN_TENS(MaxMinTens), .MAX_MIN_ONES(MaxMinOnes)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .wrap(wrap),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: total elapsed seconds plus a three-way state, updated from the spec rules.
  task automatic modelStep();
    int prevTotal;
    int prevState;
    prevTotal = mTotal;
    prevState = mState;
    mWrap = 1'b0;
    if (!reset_n) begin
      mTotal = 0;
      mState = MIdle;
      mLap   = 1'b0;
    end else if (clear) begin
      mTotal = 0;
      mState = MIdle;
      mLap   = 1'b0;
    end else begin
      if (prevState == MRun) begin
        if (tick) begin
          if (mTotal == FullScale) begin
            mTotal = 0;
            mWrap  = 1'b1;
          end else begin
            mTotal = mTotal + 1;
          end
        end
        if (stop) mState = MPause;
      end else if (start) begin
        mState = MRun;
      end
`ifdef STOPWATCH_LAP_EN
      if (prevState == MRun && lap) begin
        if (!mLap) mSnap = prevTotal;
        mLap = !mLap;
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      int d;
      d = mLap ? mSnap : mTotal;
      checkOutput("sec_ones", 8'(sec_ones), 8'((d % 60) % 10));
      checkOutput("sec_tens", 8'(sec_tens), 8'((d % 60) / 10));
      checkOutput("min_ones", 8'(min_ones), 8'((d / 60) % 10));
      checkOutput("min_tens", 8'(min_tens), 8'((d / 60) / 10));
      checkOutput("running", 8'(running), 8'(mState == MRun));
      checkOutput("wrap", 8'(wrap), 8'(mWrap));
      checkOutput("lap_active", 8'(lap_active), 8'(mLap));
    end
  end

  task automatic applyStimulus(input bit t, input bit s, input bit p, input bit c,
                               input bit l, input bit rn = 1'b1);
    tick = t; start = s; stop = p; clear = c; lap = l; reset_n = rn;
    @(posedge clk);
    modelStep();
    #2;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; reset_n = 1'b1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
  endtask

  task automatic expectDisplay(input string name, input int mt, input int mo,
                               input int st, input int so, input bit run);
    checkOutput({name, ".min_tens"}, 8'(min_tens), 8'(mt));
    checkOutput({name, ".min_ones"}, 8'(min_ones), 8'(mo));
    checkOutput({name, ".sec_tens"}, 8'(sec_tens), 8'(st));
    checkOutput({name, ".sec_ones"}, 8'(sec_ones), 8'(so));
    checkOutput({name, ".running"}, 8'(running), 8'(run));
  endtask

  initial begin
    // Reset wins even with a tick and start present.
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkEn = 1'b1;
    expectDisplay("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.wrap", 8'(wrap), 8'd0);

    applyStimulus(0, 1, 0, 0, 0);
    tickN(59);
    applyStimulus(1, 0, 0, 0, 0);
    expectDisplay("tick60", 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    tickN(15);
    expectDisplay("tick75", 0, 1, 1, 5, 1);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(9);
    applyStimulus(1, 0, 1, 0, 0);
    expectDisplay("stopTick", 0, 0, 1, 0, 0);
    tickN(5);
    expectDisplay("pausedTicks", 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    expectDisplay("startTickIgnored", 0, 0, 1, 0, 1);
    tickN(1);
    expectDisplay("resume", 0, 0, 1, 1, 1);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(FullScale);
    expectDisplay("fullScale", 5, 9, 5, 9, 1);
    applyStimulus(1, 0, 0, 0, 0);
    expectDisplay("wrapped", 0, 0, 0, 0, 1);
    checkOutput("wrap.high", 8'(wrap), 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap.low", 8'(wrap), 8'd0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(30);
    expectDisplay("at30", 0, 0, 3, 0, 1);
    applyStimulus(1, 0, 1, 1, 0);
    expectDisplay("clearWins", 0, 0, 0, 0, 0);
    tickN(1);
    expectDisplay("idleTick", 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 0, 0, 0);
    tickN(7);
    applyStimulus(1, 0, 0, 0, 0, 0);
    expectDisplay("midReset", 0, 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    applyStimulus(0, 1, 0, 0, 0);
    tickN(20);
    applyStimulus(0, 0, 0, 0, 1);
    tickN(4);
    expectDisplay("lapFrozen", 0, 0, 2, 0, 1);
    checkOutput("lap.on", 8'(lap_active), 8'd1);
    applyStimulus(0, 0, 0, 0, 1);
    expectDisplay("lapReleased", 0, 0, 2, 4, 1);
    checkOutput("lap.off", 8'(lap_active), 8'd0);
`endif

    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
                    $urandom_range(15, 0) == 0, $urandom_range(63, 0) == 0,
                    $urandom_range(15, 0) == 0, $urandom_range(199, 0) != 0);
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
